// File: rtl/quad_decoder_pkg.sv
// Shared encodings and phase helpers for the quadrature decoder.
package quad_decoder_pkg;

    typedef enum logic [1:0] {
        CTRL_HOLD = 2'b00,
        CTRL_INC  = 2'b01,
        CTRL_DEC  = 2'b10
    } ctrl_e;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    localparam int unsigned PHASE_W = 2;

    // Successor of a phase in the forward (INC) sequence 00->01->11->10->00.
    function automatic logic [PHASE_W-1:0] phase_fwd(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-1:0] n;
        case (p)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Direction of a legal single-bit phase change.
    function automatic ctrl_e phase_step(input logic [PHASE_W-1:0] prev,
                                         input logic [PHASE_W-1:0] cur);
        ctrl_e c;
        if (cur == phase_fwd(prev)) begin
            c = CTRL_INC;
        end else begin
            c = CTRL_DEC;
        end
        return c;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Quadrature inputs, enable and decoded outputs bundled as one port.
interface quad_decoder_if #(
    parameter int unsigned ERR_W = 8
);
    logic             en;
    logic             a_in;
    logic             b_in;
    logic [1:0]       control;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             ready;

    modport master (
        output en, a_in, b_in,
        input  control, err, err_cnt, ready
    );

    modport slave (
        input  en, a_in, b_in,
        output control, err, err_cnt, ready
    );
endinterface

// File: rtl/quad_chan_filter.sv
// One quadrature channel: synchronizer chain followed by an agreement filter.
module quad_chan_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CNT    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = 4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q;
    logic                   filt_q;

    assign sync = sync_q[SYNC_STAGES-1];
    assign dout = filt_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after FILT_CNT consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sync != filt_q) begin
            if (cnt_q == CNT_W'(FILT_CNT - 1)) begin
                filt_q <= sync;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phase to registered INC/DEC/err pulses.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CNT    = 4,
    parameter int unsigned ERR_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    quad_decoder_if.slave  bus
);

    localparam int unsigned SETTLE_LEN = SYNC_STAGES + FILT_CNT + 1;
    localparam int unsigned SETTLE_W   = $clog2(SETTLE_LEN);

    logic               a_f;
    logic               b_f;
    logic [PHASE_W-1:0] phase;

    state_e             state_q,   state_nx;
    logic [SETTLE_W-1:0] settle_q, settle_nx;
    logic [PHASE_W-1:0] prev_q,    prev_nx;
    ctrl_e              ctrl_q,    ctrl_nx;
    logic               err_q,     err_nx;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_nx;
    logic               ready_q,   ready_nx;

    quad_chan_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CNT    (FILT_CNT)
    ) u_chan_a (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.a_in),
        .dout (a_f)
    );

    quad_chan_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CNT    (FILT_CNT)
    ) u_chan_b (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.b_in),
        .dout (b_f)
    );

    assign phase = {a_f, b_f};

    // Next state and next outputs; previous phase always follows the filtered phase.
    always_comb begin
        state_nx   = state_q;
        settle_nx  = settle_q;
        prev_nx    = phase;
        ctrl_nx    = CTRL_HOLD;
        err_nx     = 1'b0;
        err_cnt_nx = err_cnt_q;
        case (state_q)
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_LEN - 1)) begin
                    state_nx = ST_RUN;
                end else begin
                    settle_nx = settle_q + SETTLE_W'(1);
                end
            end
            ST_RUN: begin
                if (phase != prev_q) begin
                    if ((phase ^ prev_q) == 2'b11) begin
                        err_nx = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_nx = err_cnt_q + ERR_W'(1);
                        end
                    end else if (bus.en) begin
                        ctrl_nx = phase_step(prev_q, phase);
                    end
                end
            end
            default: begin
                state_nx = ST_SETTLE;
            end
        endcase
        ready_nx = (state_nx == ST_RUN);
    end

    // State, phase history and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SETTLE;
            settle_q  <= '0;
            prev_q    <= '0;
            ctrl_q    <= CTRL_HOLD;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_nx;
            settle_q  <= settle_nx;
            prev_q    <= prev_nx;
            ctrl_q    <= ctrl_nx;
            err_q     <= err_nx;
            err_cnt_q <= err_cnt_nx;
            ready_q   <= ready_nx;
        end
    end

    assign bus.control = ctrl_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder at default parameters.
module tb_quad_decoder;
    import quad_decoder_pkg::*;

    localparam int unsigned ERR_W = 8;
    localparam int unsigned LAT   = 7;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    quad_decoder_if #(.ERR_W(ERR_W)) bus ();

    quad_decoder #(
        .SYNC_STAGES (2),
        .FILT_CNT    (4),
        .ERR_W       (ERR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        logic [1:0] exp_ctrl;
        logic       exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int exp_cnt;
        int pulses;
        int bad_ctrl;

        errors  = 0;
        checks  = 0;
        exp_cnt = 0;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, CTRL_INC,  1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, CTRL_INC,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, CTRL_INC,  1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, CTRL_INC,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, CTRL_DEC,  1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, CTRL_DEC,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, CTRL_DEC,  1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, CTRL_DEC,  1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, CTRL_HOLD, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, CTRL_HOLD, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, CTRL_HOLD, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, CTRL_HOLD, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, CTRL_HOLD, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, CTRL_HOLD, 1'b0};

        // Reset and settle with inputs idle.
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        tick();
        tick();
        check("rst_control", int'(bus.control), 0);
        check("rst_err",     int'(bus.err),     0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);
        check("rst_ready",   int'(bus.ready),   0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("settle_ready",   int'(bus.ready),   (k >= int'(LAT)) ? 1 : 0);
            check("settle_control", int'(bus.control), 0);
            check("settle_err",     int'(bus.err),     0);
        end

        // Table: each vector held 10 cycles, pulse expected exactly LAT edges later.
        for (int i = 0; i < 14; i++) begin
            bus.a_in = vecs[i].a;
            bus.b_in = vecs[i].b;
            bus.en   = vecs[i].en;
            for (int k = 1; k <= 10; k++) begin
                tick();
                check($sformatf("vec%0d_control", i), int'(bus.control),
                      (k == int'(LAT)) ? int'(vecs[i].exp_ctrl) : 0);
                check($sformatf("vec%0d_err", i), int'(bus.err),
                      (k == int'(LAT)) ? int'(vecs[i].exp_err) : 0);
                check($sformatf("vec%0d_err_cnt", i), int'(bus.err_cnt),
                      exp_cnt + (((k >= int'(LAT)) && vecs[i].exp_err) ? 1 : 0));
            end
            if (vecs[i].exp_err) exp_cnt++;
        end

        // 256 more illegal jumps (11 <-> 00): counter saturates at 255.
        pulses   = 0;
        bad_ctrl = 0;
        for (int j = 0; j < 256; j++) begin
            bus.a_in = ~bus.a_in;
            bus.b_in = ~bus.b_in;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (bus.err) pulses++;
                if (bus.control != 2'b00) bad_ctrl++;
            end
        end
        check("sat_err_pulses", pulses, 256);
        check("sat_control",    bad_ctrl, 0);
        check("sat_err_cnt",    int'(bus.err_cnt), 255);

        // Three-cycle glitch on A from phase 11: filtered out entirely.
        bus.a_in = 1'b0;
        tick();
        tick();
        tick();
        bus.a_in = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("glitch3_control", int'(bus.control), 0);
            check("glitch3_err",     int'(bus.err),     0);
        end

        // Four-cycle pulse on A just passes the filter: DEC then INC.
        bus.a_in = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.a_in = 1'b1;
        for (int k = 5; k <= 20; k++) begin
            tick();
            check("pulse4_control", int'(bus.control),
                  (k == 7) ? int'(CTRL_DEC) : ((k == 11) ? int'(CTRL_INC) : 0));
            check("pulse4_err", int'(bus.err), 0);
        end
        check("pulse4_err_cnt", int'(bus.err_cnt), 255);

        // Reset five cycles after an input change: pending step is dropped.
        bus.a_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("prerst_control", int'(bus.control), 0);
        end
        rst = 1'b1;
        tick();
        check("midrst_control", int'(bus.control), 0);
        check("midrst_err_cnt", int'(bus.err_cnt), 0);
        check("midrst_ready",   int'(bus.ready),   0);
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check("postrst_control", int'(bus.control), 0);
            check("postrst_err",     int'(bus.err),     0);
            check("postrst_err_cnt", int'(bus.err_cnt), 0);
            check("postrst_ready",   int'(bus.ready),   (k >= int'(LAT)) ? 1 : 0);
        end

        // Decoder resumes normally after the reset: 01 -> 11 is INC.
        bus.a_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("resume_control", int'(bus.control),
                  (k == int'(LAT)) ? int'(CTRL_INC) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
